inc_counter: RTL and testbench



---
 rtl/inc_counter.sv | 130 +++++++++++++
 tb/tb_inc_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/inc_counter.sv
// Loadable, clearable incrementer with carry-out pulse, sticky overflow and terminal count.
// Optional macro INC_COUNTER_SATURATE_EN: saturate at all ones instead of wrapping.

package lau_pkg;
  typedef enum logic [1:0] {SLOW, MEDIUM, FAST} speed_e;
endpackage

// Prefix AND: PO[i] = &PI[i:0], built as ripple, Sklansky or Kogge-Stone network.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of PI.
module PrefixAnd #(
  parameter int               width = 8,
  parameter lau_pkg::speed_e  speed = lau_pkg::FAST
) (
  input  logic [width-1:0] PI,
  output logic [width-1:0] PO
);
  localparam int levels = (width > 1) ? $clog2(width) : 1;

  generate
    if (speed == lau_pkg::SLOW) begin : g_ripple
      logic [width-1:0] acc;
      always_comb begin
        acc    = PI;
        for (int i = 1; i < width; i++) begin
          acc[i] = acc[i-1] & PI[i];
        end
      end
      assign PO = acc;
    end else if (speed == lau_pkg::MEDIUM) begin : g_sklansky
      logic [width-1:0] cur;
      logic [width-1:0] nxt;
      always_comb begin
        cur = PI;
        nxt = PI;
        for (int k = 0; k < levels; k++) begin
          nxt = cur;
          // Upper half of each 2^(k+1) block joins the last prefix of its lower half.
          for (int i = 0; i < width; i++) begin
            if (((i >> k) & 1) == 1) begin
              nxt[i] = cur[i] & cur[((i >> k) << k) - 1];
            end
          end
          cur = nxt;
        end
      end
      assign PO = cur;
    end else begin : g_kogge_stone
      logic [width-1:0] cur;
      logic [width-1:0] nxt;
      always_comb begin
        cur = PI;
        nxt = PI;
        for (int k = 0; k < levels; k++) begin
          nxt = cur;
          for (int i = 0; i < width; i++) begin
            if (i >= (1 << k)) begin
              nxt[i] = cur[i] & cur[i - (1 << k)];
            end
          end
          cur = nxt;
        end
      end
      assign PO = cur;
    end
  endgenerate
endmodule

// Counter: Z <= Z + CI under EN, with CLR > LD > EN > hold priority.
// Latency: one cycle from control inputs to Z/CO/OVF; TC combinational from Z.
// Backpressure: none, every edge is accepted.
module inc_counter #(
  parameter int               width = 8,
  parameter lau_pkg::speed_e  speed = lau_pkg::FAST
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             CLR,
  input  logic             LD,
  input  logic [width-1:0] D,
  input  logic             EN,
  input  logic             CI,
  output logic [width-1:0] Z,
  output logic             CO,
  output logic             OVF,
  output logic             TC
);
  logic [width:0]   po;
  logic [width-1:0] z_n;
  logic             co_n;

  // Bit i of Z toggles when CI and every lower bit of Z are set.
  PrefixAnd #(
    .width (width + 1),
    .speed (speed)
  ) u_prefix (
    .PI ({Z, CI}),
    .PO (po)
  );

  assign z_n  = Z ^ po[width-1:0];
  assign co_n = po[width];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      Z   <= '0;
      CO  <= 1'b0;
      OVF <= 1'b0;
    end else if (CLR) begin
      Z   <= '0;
      CO  <= 1'b0;
      OVF <= 1'b0;
    end else if (LD) begin
      Z   <= D;
      CO  <= 1'b0;
    end else if (EN) begin
`ifdef INC_COUNTER_SATURATE_EN
      Z   <= co_n ? {width{1'b1}} : z_n;
`else
      Z   <= z_n;
`endif
      CO  <= co_n;
      OVF <= OVF | co_n;
    end else begin
      CO  <= 1'b0;
    end
  end

  assign TC = &Z;
endmodule

// File: tb/tb_inc_counter.sv
// Bench for inc_counter: three speed variants against an arithmetic reference model.
module tb_inc_counter;
  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, ld = 1'b0, en = 1'b0, ci = 1'b0;
  logic [7:0] d = '0;

  logic [7:0] z   [NDUT];
  logic       co  [NDUT];
  logic       ovf [NDUT];
  logic       tc  [NDUT];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    inc_counter #(
      .width (8),
      .speed (lau_pkg::speed_e'(g))
    ) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .CLR    (clr),
      .LD     (ld),
      .D      (d),
      .EN     (en),
      .CI     (ci),
      .Z      (z[g]),
      .CO     (co[g]),
      .OVF    (ovf[g]),
      .TC     (tc[g])
    );
  end

  // Reference model: plain integer arithmetic on the count.
  int m_z   = 0;
  bit m_co  = 1'b0;
  bit m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int sum;
    if (!rst_n) begin
      m_z = 0; m_co = 1'b0; m_ovf = 1'b0;
    end else if (clr) begin
      m_z = 0; m_co = 1'b0; m_ovf = 1'b0;
    end else if (ld) begin
      m_z = int'(d); m_co = 1'b0;
    end else if (en) begin
      sum = m_z + (ci ? 1 : 0);
      if (sum > 255) begin
        m_co = 1'b1; m_ovf = 1'b1;
`ifdef INC_COUNTER_SATURATE_EN
        m_z = 255;
`else
        m_z = sum - 256;
`endif
      end else begin
        m_z = sum; m_co = 1'b0;
      end
    end else begin
      m_co = 1'b0;
    end
  end

  task automatic chk(input string name, input int g, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got 0x%0h expected 0x%0h", name, g, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < NDUT; g++) begin
        chk("model_z",   g, int'(z[g]),   m_z);
        chk("model_co",  g, int'(co[g]),  int'(m_co));
        chk("model_ovf", g, int'(ovf[g]), int'(m_ovf));
        chk("model_tc",  g, int'(tc[g]),  (m_z == 255) ? 1 : 0);
      end
    end
  end

  task automatic expect_all(input string name, input int ez, input int eco, input int eovf, input int etc);
    for (int g = 0; g < NDUT; g++) begin
      chk({name, "_z"},   g, int'(z[g]),   ez);
      chk({name, "_co"},  g, int'(co[g]),  eco);
      chk({name, "_ovf"}, g, int'(ovf[g]), eovf);
      chk({name, "_tc"},  g, int'(tc[g]),  etc);
    end
  endtask

  // Apply one set of controls across one rising edge, return 1 time unit after it.
  task automatic step(input bit c, input bit l, input logic [7:0] dv, input bit e, input bit i);
    clr = c; ld = l; d = dv; en = e; ci = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Counting from zero.
    step(0, 1, 8'h00, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 8'h00, 1, 1);
      expect_all("count", k, 0, 0, 0);
    end

    // Wrap or saturate from 0xFE.
    step(0, 1, 8'hFE, 0, 0);
    step(0, 0, 8'h00, 1, 1);
    expect_all("top", 8'hFF, 0, 0, 1);
    step(0, 0, 8'h00, 1, 1);
`ifdef INC_COUNTER_SATURATE_EN
    expect_all("sat1", 8'hFF, 1, 1, 1);
    step(0, 0, 8'h00, 1, 1);
    expect_all("sat2", 8'hFF, 1, 1, 1);
    step(0, 0, 8'h00, 0, 0);
    expect_all("sat_hold", 8'hFF, 0, 1, 1);
`else
    expect_all("wrap", 8'h00, 1, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    expect_all("wrap_after", 8'h00, 0, 1, 0);
    step(0, 0, 8'h00, 1, 1);
    expect_all("ovf_sticky", 8'h01, 0, 1, 0);
`endif

    // Priority CLR > LD > EN.
    step(0, 1, 8'h10, 0, 0);
    step(1, 1, 8'h33, 1, 1);
    expect_all("prio_clr", 8'h00, 0, 0, 0);
    step(0, 1, 8'h33, 1, 1);
    expect_all("prio_ld", 8'h33, 0, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    expect_all("prio_ci0", 8'h33, 0, 0, 0);

    // Asynchronous reset away from any clock edge.
    step(0, 1, 8'h5A, 0, 0);
    expect_all("pre_reset", 8'h5A, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_all("async_reset", 0, 0, 0, 0);
    #3;
    rst_n = 1'b1;
    step(0, 0, 8'h00, 1, 1);
    expect_all("resume", 1, 0, 0, 0);

    // Randomized traffic, loads biased toward the top of the range.
    for (int n = 0; n < 10000; n++) begin
      logic [7:0] dv;
      dv = ($urandom_range(3) == 0) ? (8'hFC | 8'($urandom_range(3))) : 8'($urandom);
      step(($urandom_range(63) == 0), ($urandom_range(15) == 0), dv,
           ($urandom_range(3) != 0), ($urandom_range(3) != 0));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
